// File: rtl/calculator.sv
// calculator: two-digit BCD operand calculator on a 4-digit muxed 7-seg display (clk, rst active-low async, button/operation/ret in; finalToDisplay segments and enable anodes out, both active-low)
module calculator #(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button,
  input  logic [3:0] operation,
  input  logic       ret,
  output logic [7:0] finalToDisplay,
  output logic [3:0] enable
);
  localparam int CW = $clog2(DIGIT_CYCLES + 1);
  logic [3:0] s1, s2, prev, rise, a1, a0, b1, b0, od;
  logic [1:0] v, idx;
  logic [CW-1:0] cnt;
  logic [13:0] av, bv, res;
  logic [15:0] bcd;
  logic opm, neg, dz, wrap;
  logic [7:0] disp;
  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction
  function automatic logic [3:0] inc(input logic [3:0] d, input logic r);
    return r ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
  endfunction
  assign rise = s2 & ~prev;
  assign wrap = cnt == CW'(DIGIT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      v <= '0;
      prev <= '1;
      {a1, a0, b1, b0} <= '0;
      cnt <= '0;
      idx <= '0;
      enable <= 4'b1110;
      finalToDisplay <= 8'hC0;
    end else begin
      s1 <= button;
      s2 <= s1;
      v <= {v[0], 1'b1};
      prev <= v[1] ? s2 : 4'hF;
      a1 <= inc(a1, rise[3]);
      a0 <= inc(a0, rise[2]);
      b1 <= inc(b1, rise[1]);
      b0 <= inc(b0, rise[0]);
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 2'd1 : idx;
      enable <= ~(4'b0001 << idx);
      finalToDisplay <= disp;
    end
  always_comb begin
    av = 14'(a1) * 14'd10 + 14'(a0);
    bv = 14'(b1) * 14'd10 + 14'(b0);
    opm = ret | !$onehot(operation);
    neg = operation[1] & (av < bv);
    dz = operation[3] & (bv == 14'd0);
    res = operation[0] ? av + bv :
          operation[1] ? (neg ? bv - av : av - bv) :
          operation[2] ? av * bv :
          dz ? 14'd0 : av / bv;
    bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int j = 0; j < 4; j++)
        if (bcd[j*4 +: 4] >= 4'd5) bcd[j*4 +: 4] = bcd[j*4 +: 4] + 4'd3;
      bcd = {bcd[14:0], res[i]};
    end
    od = idx == 2'd3 ? a1 : idx == 2'd2 ? a0 : idx == 2'd1 ? b1 : b0;
    disp = opm ? seg(od) & (idx == 2'd2 ? 8'h7F : 8'hFF) :
           (dz || (neg && idx == 2'd3)) ? 8'hBF :
           (idx != 2'd0 && (bcd >> {idx, 2'b00}) == 16'd0) ? 8'hFF :
           seg(bcd[{idx, 2'b00} +: 4]);
  end
endmodule

// File: tb/tb_calculator.sv
// tb_calculator: scoreboard bench for calculator, frames queued by stimulus and checked by a display-scan monitor
module tb_calculator;
  localparam int DC = 4;
  localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0, S6 = 8'h82;
  localparam logic [7:0] S8 = 8'h80, S9 = 8'h90, BL = 8'hFF, DS = 8'hBF, DP = 8'h7F;
  logic clk = 0, rst = 0, ret = 0;
  logic [3:0] button = 0, operation = 0, en;
  logic [7:0] fd;
  typedef struct {
    string name;
    logic [31:0] exp;
  } ent_t;
  ent_t q[$];
  int checks = 0, errors = 0;
  calculator #(.DIGIT_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .button(button), .operation(operation), .ret(ret),
    .finalToDisplay(fd), .enable(en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic press(input logic [3:0] m, input int n);
    repeat (n) begin
      button = m;
      repeat (4) @(negedge clk);
      button = 0;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic expect_frame(input string n, input logic [31:0] e);
    ent_t x;
    int t;
    repeat (4*DC + 4) @(negedge clk);
    x.name = n;
    x.exp = e;
    q.push_back(x);
    t = 0;
    while (q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for full scan", n);
      q.delete();
    end
  endtask
  initial begin
    logic [7:0] fr[4];
    logic [3:0] m;
    int t;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        for (int i = 0; i < 4; i++) fr[i] = 'x;
        m = 0;
        t = 0;
        while (m != 4'hF && t < 40) begin
          case (en)
            4'b1110: begin fr[0] = fd; m[0] = 1; end
            4'b1101: begin fr[1] = fd; m[1] = 1; end
            4'b1011: begin fr[2] = fd; m[2] = 1; end
            4'b0111: begin fr[3] = fd; m[3] = 1; end
            default: ;
          endcase
          t++;
          if (m != 4'hF) @(negedge clk);
        end
        if (q.size() > 0) begin
          chk({q[0].name, "_d3"}, 32'(fr[3]), 32'(q[0].exp[31:24]));
          chk({q[0].name, "_d2"}, 32'(fr[2]), 32'(q[0].exp[23:16]));
          chk({q[0].name, "_d1"}, 32'(fr[1]), 32'(q[0].exp[15:8]));
          chk({q[0].name, "_d0"}, 32'(fr[0]), 32'(q[0].exp[7:0]));
          void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    button = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset_enable", 32'(en), 32'(4'b1110));
    chk("reset_segments", 32'(fd), 32'(8'hC0));
    rst = 1;
    repeat (10) @(negedge clk);
    button = 0;
    expect_frame("held_through_reset", {S0, S0 & DP, S0, S0});
    press(4'hF, 9);
    expect_frame("all_99", {S9, S9 & DP, S9, S9});
    operation = 4'b0100;
    expect_frame("mul_9801", {S9, S8, S0, S1});
    operation = 4'b0001;
    expect_frame("add_198", {BL, S1, S9, S8});
    operation = 4'b0010;
    expect_frame("sub_0", {BL, BL, BL, S0});
    operation = 4'b1000;
    expect_frame("div_1", {BL, BL, BL, S1});
    ret = 1;
    press(4'b0001, 9);
    expect_frame("ret_9998", {S9, S9 & DP, S9, S8});
    ret = 0;
    operation = 4'b0010;
    expect_frame("sub_99_98", {BL, BL, BL, S1});
    operation = 4'b1000;
    expect_frame("div_99_98", {BL, BL, BL, S1});
    press(4'b1100, 3);
    press(4'b1000, 1);
    operation = 4'b0010;
    expect_frame("neg_66", {DS, BL, S6, S6});
    operation = 4'b1000;
    expect_frame("div_32_98", {BL, BL, BL, S0});
    operation = 4'b0100;
    expect_frame("mul_3136", {S3, S1, S3, S6});
    press(4'b0011, 2);
    operation = 4'b1000;
    expect_frame("div_32_10", {BL, BL, BL, S3});
    operation = 4'b0011;
    expect_frame("not_onehot", {S3, S2 & DP, S1, S0});
    operation = 4'b0000;
    expect_frame("op_zero", {S3, S2 & DP, S1, S0});
    press(4'b0010, 9);
    operation = 4'b1000;
    expect_frame("div_by_zero", {DS, DS, DS, DS});
    repeat (6) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("midrun_reset_enable", 32'(en), 32'(4'b1110));
    chk("midrun_reset_segments", 32'(fd), 32'(8'hC0));
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/calculator.md
CALCULATOR -- requirements
Module: calculator

Interface
REQ-001 Parameter: DIGIT_CYCLES, default 100000, clk cycles each display digit stays active (bench overrides to 4).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 button  input  4  digit-increment push buttons: [3] operand A tens, [2] A units, [1] operand B tens, [0] B units; 1 = pressed.
REQ-005 operation  input  4  one-hot operator switches: 4'b0001 add, 4'b0010 subtract, 4'b0100 multiply, 4'b1000 divide.
REQ-006 return  input  1  1 = display operands instead of result.
REQ-007 finalToDisplay  output  8  active-low segments of the enabled digit: [0]=a … [6]=g, [7]=dp.
REQ-008 enable  output  4  active-low digit anodes, [3] leftmost … [0] rightmost; exactly one bit low after reset.

Function
REQ-009 Operands A and B SHALL each be two BCD digits, range 00-99.
REQ-010 Each button bit SHALL pass through a 2-flop synchronizer; a 0->1 transition of the synchronized bit SHALL increment its digit by 1 exactly once.
REQ-011 Digit increment SHALL wrap 9->0 with no carry into the tens digit.
REQ-012 Simultaneous presses on several buttons SHALL each increment their own digit in the same cycle.
REQ-013 Increments SHALL be accepted regardless of return and operation.
REQ-014 Increment SHALL be visible in the stored digit within 4 clk cycles of the raw button rising edge.
REQ-015 Display mode SHALL be operand mode when return=1 or operation is not exactly one-hot; otherwise result mode.
REQ-016 Operand mode SHALL show A tens, A units, B tens, B units on digits 3..0, with dp lit on digit 2 only ("99.99").
REQ-017 Result mode SHALL evaluate combinationally from current A, B (value = 10*tens+units).
REQ-018 Add: A+B (0-198); multiply: A*B (0-9801); divide: integer quotient floor(A/B).
REQ-019 Subtract: if A>=B show A-B; else show magnitude B-A with a minus sign (segment g only) on digit 3.
REQ-020 Divide with B=0 SHALL show a dash (segment g only) on all four digits.
REQ-021 Result SHALL be right-aligned decimal; leading zeros blanked (all segments off), units digit always shown; dp off.
REQ-022 Binary-to-BCD conversion SHALL be combinational (double-dabble or equivalent), max 4 digits.
REQ-023 A scan counter SHALL advance the active digit every DIGIT_CYCLES cycles in order 0,1,2,3,0…; enable and finalToDisplay SHALL be registered and change in the same cycle, finalToDisplay always matching the enabled digit.
REQ-024 Mode or operand changes SHALL appear on the next refresh of each digit (latency <= 1 digit period + 1 cycle).
REQ-025 Segment encoding SHALL be standard 0-9 (e.g. 0 = 8'b11000000, 9 = 8'b10010000 incl. dp off).

Reset
REQ-026 While rst=0: A=B=00, synchronizers cleared, scan counter 0, enable=4'b1110, finalToDisplay=8'b11000000 (digit "0", dp off).
REQ-027 Reset asserted mid-press or mid-scan SHALL immediately force REQ-026 values; a button held high through reset release SHALL NOT count as a press.

Verification
REQ-028 Reset, then 9 simultaneous presses of all buttons, operation=0 -> digits show 9,9.(dp),9,9.
REQ-029 A=B=99: operation 4 -> "9801"; 1 -> " 198"; 2 -> "   0"; 8 -> "   1".
REQ-030 return=1, 9 presses of button[0] -> operand display 99.98; return=0, operation 2 -> "   1"; operation 8 -> "   1".
REQ-031 3 presses of button[3]+[2], then 1 of button[3] -> A=32; operation 2 -> "-  66" form (minus on digit 3, "66" on digits 1-0); 8 -> "   0"; 4 -> "3136".
REQ-032 2 presses of button[1]+[0] -> B=10; operation 8 -> "   3"; operation 3'b011 or 0 -> operand mode "32.10".
REQ-033 Set B=00, operation 8 -> "----"; assert rst mid-sequence -> REQ-026 values immediately.
